// File: rtl/id_seg_reg.sv
// id_seg_reg: IF/ID pipeline segment register for the RV32 pipelined core.
//
// The instruction memory is a synchronous-read RAM with a 1-cycle latency,
// addressed directly by PCF. This block registers PCD and selects the word on
// InstrD. While stalled it keeps the fetched word, because the RAM output
// moves on. On a flush it substitutes a NOP bubble.
//
// Ports:
//   clk        in   core clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   1 = advance, 0 = stall
//   clear      in   flush; has priority over en
//   PCF        in   fetch PC, which is also the RAM read address
//   imem_rdata in   RAM data for the address sampled at the previous edge
//   imem_addr  out  word address to the RAM (PCF[31:2])
//   PCD        out  registered PC of the instruction in ID
//   InstrD     out  instruction in ID
//   ValidD     out  1 = real instruction, 0 = bubble
//   StallCnt   out  saturating count of HOLD->HOLD cycles
//
// state  | meaning
// -------+----------------------------------------------------------
// RUN    | stage advanced last edge; InstrD comes straight from the RAM
// HOLD   | stalled; InstrD comes from the word captured on entry
// BUBBLE | reset or flushed; InstrD is the NOP
module id_seg_reg #(
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [31:0]      PCF,
  input  logic [31:0]      imem_rdata,
  output logic [29:0]      imem_addr,
  output logic [31:0]      PCD,
  output logic [31:0]      InstrD,
  output logic             ValidD,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] hold_q;
  logic        cnt_inc;

  // The RAM always follows PCF, whatever the state.
  assign imem_addr = PCF[31:2];

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = BUBBLE;
    end else if (en) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      state_d = HOLD;
    end
  end

  always_comb begin
    InstrD = INSTR_NOP;
    case (state_q)
      RUN:     InstrD = imem_rdata;
      HOLD:    InstrD = hold_q;
      default: InstrD = INSTR_NOP;
    endcase
  end

  // The entry edge into HOLD is not counted; only edges that stay in HOLD are.
  assign cnt_inc = (state_q == HOLD) && (state_d == HOLD) &&
                   (StallCnt != {CNT_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BUBBLE;
      PCD      <= 32'd0;
      ValidD   <= 1'b0;
      hold_q   <= INSTR_NOP;
      StallCnt <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        PCD    <= 32'd0;
        ValidD <= 1'b0;
      end else if (en) begin
        PCD    <= PCF;
        ValidD <= 1'b1;
      end else if (state_q == RUN) begin
        // Capture the word that is on InstrD now; the RAM output changes next cycle.
        hold_q <= imem_rdata;
      end
      if (cnt_inc) begin
        StallCnt <= StallCnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/id_seg_reg.md
Name: id_seg_reg

Overview:
- IF/ID pipeline segment register of the RV32 pipelined core. Sits directly upstream of the immediate generator and decoder, and feeds them InstrD[31:7] and the full InstrD.
- Instruction memory is a synchronous-read block RAM with 1-cycle latency, addressed by PCF. This block registers PCD and presents the fetched instruction.
- Across stalls it preserves the fetched word, because the RAM output moves on while PCF is held. On flush it substitutes a NOP bubble.

Parameters:
- INSTR_NOP, 32'h00000013, instruction word driven during bubbles (addi x0,x0,0).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  1 = stage advances; 0 = stall (hold).
- clear  input  1  flush; has priority over en.
- PCF  input  32  fetch-stage PC, also the RAM read address (driven externally).
- imem_rdata  input  32  RAM read data; reflects the address sampled at the previous clock edge.
- imem_addr  output  30  word address to the RAM, equal to PCF[31:2] (combinational).
- PCD  output  32  registered PC of the instruction in ID.
- InstrD  output  32  instruction in ID.
- ValidD  output  1  1 = InstrD/PCD is a real instruction; 0 = bubble.
- StallCnt  output  CNT_W  number of cycles spent in HOLD.

Behaviour:
- Reset (asynchronous, immediate, regardless of clk):
  - state=BUBBLE, PCD=0, ValidD=0, hold_q=INSTR_NOP, StallCnt=0.
  - InstrD=INSTR_NOP while rst is high and after rst deasserts, until the first advancing edge.
- State machine (registered state; InstrD is a combinational mux from state):
  - RUN: InstrD=imem_rdata.
  - HOLD: InstrD=hold_q.
  - BUBBLE: InstrD=INSTR_NOP.
- Transitions at each rising edge (rst low), in priority order:
  - clear=1 -> BUBBLE; PCD<=0; ValidD<=0. Applies from any state, and en is ignored.
  - clear=0, en=1 -> RUN; PCD<=PCF; ValidD<=1.
  - clear=0, en=0, state=RUN -> HOLD; hold_q<=imem_rdata (the word currently on InstrD); PCD and ValidD unchanged.
  - clear=0, en=0, state=HOLD -> HOLD; hold_q unchanged.
  - clear=0, en=0, state=BUBBLE -> BUBBLE; everything unchanged.
- Latency: PCF sampled at edge N appears on PCD after edge N, and its instruction appears on InstrD in the same cycle via imem_rdata. There are no extra pipeline cycles.
- Stall length: any stall of k>=1 cycles must present the same InstrD on every cycle of the stall. After the stall ends, InstrD shows the word fetched at the next PCF.
- StallCnt: increments by 1 on every edge where state is HOLD at the edge and the next state is also HOLD. It saturates at all-ones with no wrap, and is cleared only by rst.
- Combined events:
  - clear=1 with en=0 still flushes.
  - clear during HOLD discards hold_q; it is not cleared, but is unused until the next RUN->HOLD capture.
- Reset asserted mid-stall returns to BUBBLE immediately.
- imem_addr is independent of state; the RAM always reads PCF.

Test Plan:
- Reset: assert rst mid-cycle -> outputs go to InstrD=32'h00000013, ValidD=0, PCD=0, StallCnt=0 before the next edge.
- Straight-line: PCF=0,4,8 with en=1 and RAM returning 32'h00500093, 32'h00a00113, 32'h002081b3 -> PCD and InstrD track with 1-edge latency; ValidD=1 from the first advance.
- Stall: at PCD=4 / InstrD=32'h00a00113, hold en=0 for 3 cycles while RAM output changes to 32'h002081b3 -> InstrD stays 32'h00a00113 and StallCnt=2. After en=1, PCD=8 and InstrD=32'h002081b3.
- Flush: clear=1 for one edge while in RUN at PCD=8 -> next cycle InstrD=32'h00000013, PCD=0, ValidD=0. The next en=1 edge resumes at the new PCF=32'h00000040.
- Flush during stall: state HOLD, clear=1 with en=0 -> BUBBLE. Held word is not re-presented after en returns.
- Saturation: with CNT_W=4, stall 20 cycles -> StallCnt sticks at 4'hF.
